muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller beside the EX stage of the pipelined MIPS datapath; executes MULT, MULTU, DIV and DIVU.
- Owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Drives a combinational stall to the hazard logic while an operation is in flight, so the single-cycle ALU path never waits on it.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  EX-stage mult/div issue, one cycle.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  in  WIDTH  rs operand (multiplicand/dividend).
- B  in  WIDTH  rt operand (multiplier/divisor).
- HiLoRead  in  1  MFHI/MFLO in EX.
- HiWrite  in  1  MTHI.
- LoWrite  in  1  MTLO.
- WrData  in  WIDTH  MTHI/MTLO data.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse when Hi/Lo are updated by an operation.
- DivZero  out  1  valid with Done; divisor was zero.
- Stall  out  1  combinational pipeline stall request.

Behaviour:
- Reset (async, any state): state IDLE; Hi, Lo, counter and internal accumulators 0; Busy, Done, DivZero 0.
- FSM states: IDLE, RUN, FIXUP.
- IDLE: on the edge where Start=1, latch Op, |A|, |B| (magnitudes for signed ops) and the sign bits; counter=0; go to RUN; Busy=1 from that edge.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per edge. Counter increments; after WIDTH steps go to FIXUP.
- FIXUP: apply signs, then on the next edge write Hi/Lo, pulse Done for one cycle, set DivZero, clear Busy, return to IDLE.
- Latency: Start edge E0; Busy high for WIDTH+1 cycles; Hi/Lo valid and Done=1 after edge E(WIDTH+1).
- Multiply: {Hi,Lo} = 2*WIDTH-bit product. For MULT, negate the product when sA^sB.
- Divide: Lo = quotient, Hi = remainder.
  - Signed: quotient negated when sA^sB; remainder takes the sign of A.
  - Overflow case 0x80000000 / -1: Lo=0x80000000, Hi=0.
- Divide by zero (DIV or DIVU): Hi=A, Lo=all ones, DivZero=1 with Done. Latency is unchanged.
- DivZero holds until the next Start is accepted; it is cleared on that edge.
- MTHI/MTLO accepted in IDLE only: HiWrite/LoWrite load WrData on the edge. Simultaneous HiWrite and LoWrite write both.
- Stall = Busy & (Start | HiLoRead | HiWrite | LoWrite).
  - The pipeline holds the instruction; it is re-presented each cycle and accepted in the cycle Busy falls.
  - In the Done cycle Busy=0, so MFHI sees the new value with no extra bubble.
- Start while Busy: ignored (stalled), with no effect on the running operation.
- Start together with HiWrite/LoWrite in IDLE: Start wins; the MT write is dropped. The decoder never issues both.
- Reset mid-operation: aborts immediately; no Done pulse; Hi/Lo read 0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply with A==0 or B==0, and any divide with B==0, skips RUN and goes IDLE->FIXUP.
  - Done follows after edge E2.
  - Results are identical to the full path: 0 product; div-by-zero values above.
- Undefined: every operation takes WIDTH+1 cycles.

Decomposition:
- Shared package: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state encodings, the WIDTH default.
- Sub-module muldiv_step: one combinational iteration step (add/shift or trial-subtract/shift) selected by mult/div.
- FSM, counter, sign fix-up and HI/LO registers stay in muldiv_sequencer.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; Done exactly 33 cycles after the Start edge.
- MULT A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100, B=0 -> Hi=100, Lo=0xFFFFFFFF, DivZero=1. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- HiLoRead held from cycle 2 after Start -> Stall=1 until the Done cycle, then 0; Hi reads the new product.
- Second Start during Busy -> Stall=1; first result is unaffected; second operation begins in the Done cycle.
- Reset asserted 10 cycles into a DIVU -> Busy=0, Hi=Lo=0 immediately, no Done. MTLO 0x1234 afterwards -> Lo=0x1234.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Optional early-out path is enabled with MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or restoring divide step.
// Works on unsigned magnitudes held in a {hi,lo} accumulator pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // select add/shift-right or trial-subtract/shift-left
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    sh   = {hi_i, lo_i[WIDTH-1]};
    diff = sh - {1'b0, m_i};
    if (div_i) begin
      hi_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and iterative MULT/MULTU/DIV/DIVU controller.
// MULDIV_EARLY_OUT_EN: trivial operands bypass the iteration loop.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_dz;

`ifdef MULDIV_EARLY_OUT_EN
  logic early_q, early_d;
  logic early_in;
  assign early_in = Op[1] ? (B == '0) : ((A == '0) || (B == '0));
`endif

  // signed ops (MULT, DIV) have Op[0]==0
  assign a_neg = ~Op[0] & A[WIDTH-1];
  assign b_neg = ~Op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Stall   = Busy & (Start | HiLoRead | HiWrite | LoWrite);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (op_q[1]),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .m_i   (m_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  // sign fix-up of the unsigned magnitude result
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod   = {acc_hi_q, acc_lo_q};
    quo    = acc_lo_q;
    rem    = acc_hi_q;
    res_dz = 1'b0;
    if (sa_q ^ sb_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (sa_q) rem = -rem;
    if (op_q[1]) begin
      if (m_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    m_d      = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
`ifdef MULDIV_EARLY_OUT_EN
    early_d  = early_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d     = Op;
          sa_d     = a_neg;
          sb_d     = b_neg;
          a_d      = A;
          m_d      = Op[1] ? b_mag : a_mag;
          acc_hi_d = '0;
          acc_lo_d = Op[1] ? a_mag : b_mag;
          cnt_d    = '0;
          dz_d     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
          early_d  = early_in;
          if (early_in) acc_lo_d = '0;
          state_d  = early_in ? FIXUP : RUN;
`else
          state_d  = RUN;
`endif
        end else begin
          if (HiWrite) hi_d = WrData;
          if (LoWrite) lo_d = WrData;
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIXUP;
      end
      FIXUP: begin
`ifdef MULDIV_EARLY_OUT_EN
        if (early_q && (cnt_q == '0)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
`else
        begin
`endif
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          dz_d    = res_dz;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      m_q      <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
`ifdef MULDIV_EARLY_OUT_EN
      early_q  <= early_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, stalls,
// back-to-back issue, mid-operation reset and MTHI/MTLO.
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        HiLoRead = 1'b0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] WrData = '0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivZero, Stall;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .A(A), .B(B), .HiLoRead(HiLoRead), .HiWrite(HiWrite),
    .LoWrite(LoWrite), .WrData(WrData), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: every Done pulse is matched against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_hi"}, 64'(Hi), 64'(e.hi));
          chk({e.nm, "_lo"}, 64'(Lo), 64'(e.lo));
          chk({e.nm, "_dz"}, 64'(DivZero), 64'(e.dz));
          if (e.at != 0) chk({e.nm, "_lat"}, 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  // Start is sampled at the next posedge (E0); Done is seen at the
  // negedge after E33, i.e. cyc = issue-negedge cyc + 34
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input logic edz,
                       input string nm, input bit push);
    exp_t e;
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.at = cyc + 34; e.nm = nm;
      sb.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (Done) return;
    end
    chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int bad;
    bit ok;
    int seen;
    exp_t e;

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(DivZero), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max", 1'b1);
    wait_done("multu_max");

    issue(2'b00, 32'hFFFFFFFD, 32'd7,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg", 1'b1);
    wait_done("mult_neg");

    issue(2'b10, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg", 1'b1);
    wait_done("div_neg");

    issue(2'b11, 32'd100, 32'd0,
          32'd100, 32'hFFFFFFFF, 1'b1, "divu_zero", 1'b1);
    wait_done("divu_zero");
    @(negedge Clk);
    chk("dz_hold", 64'(DivZero), 64'd1);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000, 1'b0, "div_ovf", 1'b1);
    wait_done("div_ovf");

    // MFHI held while busy must stall until the Done cycle
    issue(2'b01, 32'h12345678, 32'h00000100,
          32'h00000012, 32'h34567800, 1'b0, "multu_rd", 1'b1);
    @(negedge Clk);
    HiLoRead = 1'b1;
    #1;
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin
        chk("rd_stall_done", 64'(Stall), 64'd0);
        chk("rd_hi_new", 64'(Hi), 64'h12);
        ok = 1'b1;
        break;
      end
      if (Stall !== 1'b1) bad++;
      @(negedge Clk);
      #1;
    end
    chk("rd_stall_hold", 64'(bad), 64'd0);
    chk("rd_found_done", 64'(ok), 64'd1);
    HiLoRead = 1'b0;
    @(negedge Clk);

    // second Start while busy is held off until the Done cycle
    issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "multu_a", 1'b1);
    repeat (3) @(negedge Clk);
    Start = 1'b1;
    Op = 2'b11;
    A = 32'd100;
    B = 32'd7;
    #1;
    chk("b2b_stall", 64'(Stall), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Stall == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_released", 64'(ok), 64'd1);
    chk("b2b_in_done", 64'(Done), 64'd1);
    e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0; e.at = cyc + 34;
    e.nm = "divu_b";
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b_busy", 64'(Busy), 64'd1);
    wait_done("divu_b");
    @(negedge Clk);

    // reset 10 cycles into a DIVU: abort with no Done
    issue(2'b11, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, "abort", 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    LoWrite = 1'b1;
    WrData = 32'h1234;
    @(negedge Clk);
    LoWrite = 1'b0;
    chk("mtlo_lo", 64'(Lo), 64'h1234);
    chk("mtlo_hi", 64'(Hi), 64'd0);

    HiWrite = 1'b1;
    LoWrite = 1'b1;
    WrData = 32'hABCD;
    @(negedge Clk);
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    chk("mtboth_hi", 64'(Hi), 64'hABCD);
    chk("mtboth_lo", 64'(Lo), 64'hABCD);

    // Start with MTLO in IDLE: the write is dropped
    @(negedge Clk);
    Start = 1'b1;
    Op = 2'b01;
    A = 32'd2;
    B = 32'd3;
    LoWrite = 1'b1;
    WrData = 32'hDEAD;
    e.hi = 32'd0; e.lo = 32'd6; e.dz = 1'b0; e.at = cyc + 34;
    e.nm = "multu_mt";
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    LoWrite = 1'b0;
    chk("start_wins_lo", 64'(Lo), 64'hABCD);
    chk("start_wins_busy", 64'(Busy), 64'd1);
    wait_done("multu_mt");

    repeat (3) @(negedge Clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
